// File: rtl/imem_fetch_if.sv
// Fetch-unit bundle: instruction-memory port, redirect request and decode-side handshake.
// The master modport is the fetch unit; the slave modport is memory plus decode/execute.
interface imem_fetch_if;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic        imem_wr;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;

  modport master (
    output imem_addr, imem_en, imem_wr, out_valid, out_instr, out_pc, halted,
    input  imem_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, imem_en, imem_wr, out_valid, out_instr, out_pc, halted,
    output imem_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: 16-bit PC, 2-entry {instr, pc} buffer, redirect flush.
// Optional HLT detection is enabled with the FETCH_HALT_DETECT_EN macro.
module imem_fetch_unit (
  input  logic         clk,
  input  logic         rst,
  imem_fetch_if.master bus
);
  typedef enum logic [1:0] {StBoot, StFetch, StHalted} state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [1:0]  count_q;
  logic        head_q;
  logic [15:0] fifo_instr_q [2];
  logic [15:0] fifo_pc_q    [2];

  logic pop;
  logic push;
  logic fetch_en;
  logic halt_hit;
  logic tail;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = bus.redirect_pc[0];

  always_comb begin
    pop      = (count_q != 2'd0) && bus.out_ready;
    // A full buffer can still fetch when the head leaves in the same cycle.
    fetch_en = (state_q == StFetch) && ((count_q != 2'd2) || pop);
    push     = fetch_en && !bus.redirect;
    tail     = head_q ^ count_q[0];
`ifdef FETCH_HALT_DETECT_EN
    halt_hit = push && (bus.imem_data[15:12] == 4'hF);
`else
    halt_hit = 1'b0;
`endif
  end

  assign bus.imem_addr = pc_q;
  assign bus.imem_en   = fetch_en;
  assign bus.imem_wr   = 1'b0;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_instr = fifo_instr_q[head_q];
  assign bus.out_pc    = fifo_pc_q[head_q];
  assign bus.halted    = (state_q == StHalted);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= 16'h0000;
      count_q <= 2'd0;
      head_q  <= 1'b0;
    end else if (bus.redirect) begin
      state_q <= StFetch;
      pc_q    <= {bus.redirect_pc[15:1], 1'b0};
      count_q <= 2'd0;
      head_q  <= 1'b0;
    end else begin
      if (push) begin
        fifo_instr_q[tail] <= bus.imem_data;
        fifo_pc_q[tail]    <= pc_q;
        pc_q               <= pc_q + 16'd2;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      unique case (state_q)
        StBoot:   state_q <= StFetch;
        StFetch:  if (halt_hit) state_q <= StHalted;
        StHalted: state_q <= StHalted;
        default:  state_q <= StBoot;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: directed scenarios push expected {instr, pc}
// pairs, an independent negedge monitor pops and compares on every accepted handshake.
module tb_imem_fetch_unit;
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] mem [0:32767];
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int drain_n = 0;

  imem_fetch_if bus ();

  imem_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_data = mem[bus.imem_addr[15:1]];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_item(input logic [15:0] instr, input logic [15:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted instruction must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && !bus.redirect && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_item: got instr 0x%04h pc 0x%04h, expected none",
                 bus.out_instr, bus.out_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_instr", bus.out_instr, e.instr);
        check("out_pc", bus.out_pc, e.pc);
      end
    end
  end

  // Waits until the scoreboard is empty, then stalls decode right after the last handshake.
  task automatic drain(input int max_cycles);
    drain_n = 0;
    while (exp_q.size() != 0 && drain_n < max_cycles) begin
      @(posedge clk);
      drain_n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending items, expected 0", exp_q.size());
      exp_q.delete();
    end
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic do_reset(input logic ready);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.out_ready = ready;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [15:0] target, input logic ready_after);
    @(posedge clk);
    #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    @(posedge clk);
    #1;
    bus.redirect  = 1'b0;
    bus.out_ready = ready_after;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i] = {4'h1, 12'(i)};
    end
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.out_ready   = 1'b0;

    // Reset release, latency and first two words.
    expect_item(16'h1111, 16'h0000);
    expect_item(16'h2222, 16'h0002);
    expect_item(16'h1002, 16'h0004);
    expect_item(16'h1003, 16'h0006);
    do_reset(1'b1);
    @(negedge clk);
    check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    check("rst_imem_en", {15'd0, bus.imem_en}, 16'd0);
    check("rst_imem_wr", {15'd0, bus.imem_wr}, 16'd0);
    check("rst_halted", {15'd0, bus.halted}, 16'd0);
    check("rst_pc", bus.imem_addr, 16'h0000);
    @(negedge clk);
    check("boot_out_valid", {15'd0, bus.out_valid}, 16'd0);
    check("fetch_imem_en", {15'd0, bus.imem_en}, 16'd1);
    @(negedge clk);
    check("latency_out_valid", {15'd0, bus.out_valid}, 16'd1);
    drain(20);

    // Back-pressure: buffer fills, fetch stops, then full-rate drain.
    do_reset(1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("full_imem_en", {15'd0, bus.imem_en}, 16'd0);
    check("full_out_valid", {15'd0, bus.out_valid}, 16'd1);
    check("full_pc", bus.imem_addr, 16'h0004);
    expect_item(16'h1111, 16'h0000);
    expect_item(16'h2222, 16'h0002);
    expect_item(16'h1002, 16'h0004);
    expect_item(16'h1003, 16'h0006);
    expect_item(16'h1004, 16'h0008);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain(20);
    check("throughput_cycles", 16'(drain_n), 16'd5);

    // Redirect while full: flush, odd target aligned, two-cycle latency.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_redirect_full", {15'd0, bus.imem_en}, 16'd0);
    expect_item(16'h1020, 16'h0040);
    expect_item(16'h1021, 16'h0042);
    expect_item(16'h1022, 16'h0044);
    do_redirect(16'h0041, 1'b1);
    @(negedge clk);
    check("flush_out_valid", {15'd0, bus.out_valid}, 16'd0);
    check("redirect_pc_aligned", bus.imem_addr, 16'h0040);
    @(negedge clk);
    check("redirect_latency_valid", {15'd0, bus.out_valid}, 16'd1);
    drain(20);

    // PC wrap from 0xFFFE to 0x0000.
    @(posedge clk);
    #1 exp_q.delete();
    do_redirect(16'h0040, 1'b0);
    repeat (3) @(posedge clk);
    expect_item(16'h1FFF, 16'hFFFE);
    expect_item(16'h1111, 16'h0000);
    expect_item(16'h2222, 16'h0002);
    do_redirect(16'hFFFE, 1'b1);
    drain(20);

    // Reset overrides redirect while the buffer is full.
    repeat (4) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0100;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.redirect = 1'b0;
    bus.out_ready = 1'b1;
    expect_item(16'h1111, 16'h0000);
    expect_item(16'h2222, 16'h0002);
    @(negedge clk);
    check("rst_redirect_valid", {15'd0, bus.out_valid}, 16'd0);
    check("rst_redirect_pc", bus.imem_addr, 16'h0000);
    check("rst_redirect_boot", {15'd0, bus.imem_en}, 16'd0);
    drain(20);

    // HLT opcode at 0x0004.
    mem[2] = 16'hF000;
    expect_item(16'h1111, 16'h0000);
    expect_item(16'h2222, 16'h0002);
    expect_item(16'hF000, 16'h0004);
`ifndef FETCH_HALT_DETECT_EN
    expect_item(16'h1003, 16'h0006);
`endif
    do_reset(1'b1);
    drain(20);
    @(negedge clk);
`ifdef FETCH_HALT_DETECT_EN
    check("halted_set", {15'd0, bus.halted}, 16'd1);
    check("halted_imem_en", {15'd0, bus.imem_en}, 16'd0);
    check("halted_empty", {15'd0, bus.out_valid}, 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("halted_pc_hold", bus.imem_addr, 16'h0006);
    check("halted_still_idle", {15'd0, bus.imem_en}, 16'd0);
    expect_item(16'h1111, 16'h0000);
    expect_item(16'h2222, 16'h0002);
    do_redirect(16'h0000, 1'b1);
    @(negedge clk);
    check("halted_cleared", {15'd0, bus.halted}, 16'd0);
    check("resume_imem_en", {15'd0, bus.imem_en}, 16'd1);
    drain(20);
`else
    check("no_halt", {15'd0, bus.halted}, 16'd0);
    check("no_halt_imem_en", {15'd0, bus.imem_en}, 16'd1);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
